cmp_arbiter4: RTL

CMP_ARBITER4 -- requirements
Module: cmp_arbiter4

---
 rtl/cmp_arbiter4.sv | 139 +++++++++++++
 1 files changed

// File: rtl/cmp_arbiter4.sv
// Round-robin arbiter sharing one registered magnitude comparator
// among NREQ requesters; one 3-cycle transaction at a time.
module cmp_arbiter4 #(
    parameter int NREQ = 4,
    parameter int W    = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] opa,
    input  logic [NREQ*W-1:0] opb,
    output logic [NREQ-1:0]   ack,
    output logic              res_gt,
    output logic              res_lt,
    output logic              res_eq,
    output logic              busy,
    output logic [W-1:0]      cmp_a,
    output logic [W-1:0]      cmp_b,
    input  logic              cmp_gt,
    input  logic              cmp_lt,
    output logic              cmp_err
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        RESP
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] last_q, last_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           gt_q, gt_d;
    logic           lt_q, lt_d;
    logic           err_q, err_d;

    logic [IDW-1:0] win;
    logic [IDW-1:0] cand;
    logic           found;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;

    // Search starts one past the last served id and wraps modulo NREQ.
    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = last_q + IDW'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                sel_a = opa[i*W +: W];
                sel_b = opb[i*W +: W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        last_d  = last_q;
        a_d     = a_q;
        b_d     = b_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        err_d   = err_q;
        ack     = '0;
        res_gt  = 1'b0;
        res_lt  = 1'b0;
        res_eq  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    id_d    = win;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                gt_d    = cmp_gt;
                lt_d    = cmp_lt;
                err_d   = err_q | (cmp_gt & cmp_lt);
                state_d = RESP;
            end
            RESP: begin
                ack[id_q] = 1'b1;
                res_gt    = gt_q;
                res_lt    = lt_q;
                res_eq    = ~gt_q & ~lt_q;
                last_d    = id_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            last_q  <= IDW'(NREQ - 1);
            a_q     <= '0;
            b_q     <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            err_q   <= err_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign cmp_a   = a_q;
    assign cmp_b   = b_q;
    assign cmp_err = err_q;

endmodule
